// File: rtl/gouram_datatypes.sv
// Shared types for the gouram trace path: filter FSM states, kill-bit indices
// and the wrap-safe timestamp compare.
package gouram_datatypes;

  localparam int KILL_JUMP_DONE    = 0;
  localparam int KILL_BRANCH_TAKEN = 1;

  typedef enum logic [1:0] {
    FWF_IDLE,
    FWF_WAIT_WIN,
    FWF_DECIDE,
    FWF_OUTPUT
  } fwf_state_t;

  // True when a is strictly later than b on a w-bit wrapping time line.
  function automatic logic ts_after(input logic [63:0] a, input logic [63:0] b,
                                    input int unsigned w);
    logic [63:0] d;
    logic [63:0] m;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    d = (a - b) & m;
    return (d != 64'd0) && !(1'(d >> (w - 1)));
  endfunction

endpackage

// File: rtl/decode_window_recorder.sv
// Records decode windows (start, end, accumulated kill mask) into a circular
// FIFO that overwrites its oldest entry when full.
module decode_window_recorder #(
  parameter int TS_WIDTH      = 32,
  parameter int KILL_SOURCES  = 2,
  parameter int HISTORY_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [TS_WIDTH-1:0]     counter,
  input  logic                    is_decoding,
  input  logic [KILL_SOURCES-1:0] kill_i,
  input  logic                    pop,
  output logic [TS_WIDTH-1:0]     head_start,
  output logic [TS_WIDTH-1:0]     head_end,
  output logic [KILL_SOURCES-1:0] head_mask,
  output logic                    empty,
  output logic                    overflow
);

  localparam int AW = $clog2(HISTORY_DEPTH);

  typedef struct packed {
    logic [TS_WIDTH-1:0]     start;
    logic [TS_WIDTH-1:0]     stop;
    logic [KILL_SOURCES-1:0] mask;
  } win_t;

  win_t                    mem [HISTORY_DEPTH];
  logic [AW-1:0]           rd_ptr, wr_ptr;
  logic [AW:0]             count;
  logic                    dec_q, open;
  logic [TS_WIDTH-1:0]     cur_start;
  logic [KILL_SOURCES-1:0] cur_mask;
  logic                    push, full, do_pop;

  // open guards against a bogus push when a window was already in flight at
  // reset release (dec_q resets high, so no rise is ever seen for it).
  assign push   = dec_q && !is_decoding && open;
  assign full   = (count == (AW+1)'(HISTORY_DEPTH));
  assign empty  = (count == '0);
  assign do_pop = pop && !empty;

  assign head_start = mem[rd_ptr].start;
  assign head_end   = mem[rd_ptr].stop;
  assign head_mask  = mem[rd_ptr].mask;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{start: cur_start,
                       stop:  counter - TS_WIDTH'(1),
                       mask:  cur_mask | kill_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q     <= 1'b1;
      open      <= 1'b0;
      cur_start <= '0;
      cur_mask  <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      dec_q <= is_decoding;
      if (!dec_q && is_decoding) begin
        open      <= 1'b1;
        cur_start <= counter;
        cur_mask  <= kill_i;
      end else if (dec_q && is_decoding) begin
        cur_mask <= cur_mask | kill_i;
      end else if (push) begin
        open <= 1'b0;
      end

      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      // A push into a full FIFO without a pop drags the read side along.
      if (do_pop || (push && full))
        rd_ptr <= rd_ptr + AW'(1);
      if (push && full && !do_pop)
        overflow <= 1'b1;

      if (push && !do_pop && !full)
        count <= count + (AW+1)'(1);
      else if (do_pop && !push)
        count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/flush_window_filter.sv
// Pairs each trace element with the next decode window and drops it if that
// window saw a kill. Optional counters: define GOURAM_FILTER_STATS_EN.
module flush_window_filter
  import gouram_datatypes::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int TS_WIDTH      = 32,
  parameter int KILL_SOURCES  = 2,
  parameter int HISTORY_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [TS_WIDTH-1:0]     counter,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [TS_WIDTH-1:0]     in_if_end,
  input  logic                    is_decoding,
  input  logic [KILL_SOURCES-1:0] kill_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [TS_WIDTH-1:0]     out_if_end,
  output logic [TS_WIDTH-1:0]     out_dec_start,
  output logic [TS_WIDTH-1:0]     out_dec_end,
  output logic                    drop_pulse,
  output logic [KILL_SOURCES-1:0] drop_mask,
  output logic                    window_overflow
`ifdef GOURAM_FILTER_STATS_EN
  ,
  output logic [31:0]             pass_count,
  output logic [31:0]             drop_count
`endif
);

  fwf_state_t              state;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [TS_WIDTH-1:0]     if_end_q, win_start, win_end;
  logic [KILL_SOURCES-1:0] win_mask;
  logic [TS_WIDTH-1:0]     head_start, head_end;
  logic [KILL_SOURCES-1:0] head_mask;
  logic                    empty, pop, head_fresh;

  assign pop        = (state == FWF_WAIT_WIN) && !empty;
  assign head_fresh = ts_after(64'(head_start), 64'(if_end_q), TS_WIDTH);

  decode_window_recorder #(
    .TS_WIDTH      (TS_WIDTH),
    .KILL_SOURCES  (KILL_SOURCES),
    .HISTORY_DEPTH (HISTORY_DEPTH)
  ) u_rec (
    .clk         (clk),
    .rst         (rst),
    .counter     (counter),
    .is_decoding (is_decoding),
    .kill_i      (kill_i),
    .pop         (pop),
    .head_start  (head_start),
    .head_end    (head_end),
    .head_mask   (head_mask),
    .empty       (empty),
    .overflow    (window_overflow)
  );

  // in_ready/out_valid track the next state so they stay pure state decodes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FWF_IDLE;
      in_ready      <= 1'b0;
      out_valid     <= 1'b0;
      data_q        <= '0;
      if_end_q      <= '0;
      win_start     <= '0;
      win_end       <= '0;
      win_mask      <= '0;
      out_data      <= '0;
      out_if_end    <= '0;
      out_dec_start <= '0;
      out_dec_end   <= '0;
      drop_pulse    <= 1'b0;
      drop_mask     <= '0;
    end else begin
      drop_pulse <= 1'b0;
      case (state)
        FWF_IDLE: begin
          if (in_valid && in_ready) begin
            data_q   <= in_data;
            if_end_q <= in_if_end;
            in_ready <= 1'b0;
            state    <= FWF_WAIT_WIN;
          end else begin
            in_ready <= 1'b1;
          end
        end
        FWF_WAIT_WIN: begin
          // Stale heads are popped by the pop decode and we simply stay here.
          if (!empty && head_fresh) begin
            win_start <= head_start;
            win_end   <= head_end;
            win_mask  <= head_mask;
            state     <= FWF_DECIDE;
          end
        end
        FWF_DECIDE: begin
          if (win_mask != '0) begin
            drop_pulse <= 1'b1;
            drop_mask  <= win_mask;
            in_ready   <= 1'b1;
            state      <= FWF_IDLE;
          end else begin
            out_valid     <= 1'b1;
            out_data      <= data_q;
            out_if_end    <= if_end_q;
            out_dec_start <= win_start;
            out_dec_end   <= win_end;
            state         <= FWF_OUTPUT;
          end
        end
        FWF_OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= FWF_IDLE;
          end
        end
        default: state <= FWF_IDLE;
      endcase
    end
  end

`ifdef GOURAM_FILTER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_count <= '0;
      drop_count <= '0;
    end else begin
      if (out_valid && out_ready && (pass_count != '1))
        pass_count <= pass_count + 32'd1;
      if (drop_pulse && (drop_count != '1))
        drop_count <= drop_count + 32'd1;
    end
  end
`endif

endmodule
